disk_track_loader: RTL and testbench
====================================

# disk_track_loader

Multi-drive track cache controller between the disk-controller emulation (Disk II style, track-granular buffers) and the HPS virtual-disk port. Each drive slot needs a whole track in block RAM. The block loads the requested track, sector by sector, into that buffer, and writes a modified track back to the image before it replaces it. It also holds off the CPU while a transfer runs. It supersedes the single-drive, read-only track loader in the top level.

## Interface
Parameters:
- DRIVES, 2: number of drive slots, 1..4; DW = max(1, clog2(DRIVES)).
- SPT, 13: 512-byte image blocks per track, 1..16.
- TRACK_W, 6: width of a track number.
- SEC_W, 4: buffer sector index width; must satisfy 2^SEC_W >= SPT.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  reset, asynchronous assert, active low; also driven low on cold/warm reset.
- track  in  DRIVES*TRACK_W  requested track per drive; drive d occupies bits [d*TRACK_W +: TRACK_W].
- img_mounted  in  DRIVES  one-cycle mount/eject pulse per drive.
- img_size_nz  in  1  image size nonzero; sampled with the img_mounted pulse.
- img_readonly  in  1  sampled with the img_mounted pulse.
- wr_strobe  in  1  the controller wrote a byte into a track buffer.
- wr_drive  in  DW  drive number for wr_strobe.
- sd_lba  out  32  block address for the active transfer, shared by all drives.
- sd_rd  out  DRIVES  read request per drive.
- sd_wr  out  DRIVES  write request per drive.
- sd_ack  in  DRIVES  HPS acknowledge per drive; high while a block is moving.
- buf_drive  out  DW  drive whose buffer is being accessed.
- buf_sec  out  SEC_W  buffer sector; the HPS byte address extends it: {buf_drive, buf_sec, sd_buff_addr}.
- cpu_wait  out  1  stall the CPU.
- busy  out  DRIVES  per-drive: a transfer is in progress or pending.

## Operation
Per-drive state:
- present: image mounted with nonzero size.
- ro: image is read-only.
- loaded: the buffer holds a valid track.
- dirty: the buffer differs from the image.
- cur_track: the track held in the buffer, TRACK_W bits.

Mount pulse on drive d:
- present[d] <= img_size_nz; ro[d] <= img_readonly.
- loaded[d] <= 0 and dirty[d] <= 0, so pending changes are discarded.
- If drive d is mid-transfer, the transfer completes and d is then reloaded.

Dirty marking:
- wr_strobe sets dirty[wr_drive] when present & loaded & ~ro.
- A strobe in the same cycle as the clear at FLUSH entry wins, so dirty stays set.

Service:
- Drive d needs service when present[d] & (~loaded[d] | cur_track[d] != track[d]).
- Among drives that need service, the lowest index is chosen.
- busy[d] = needs service, or d is the active drive.

FSM states: IDLE, FLUSH, LOAD.
- IDLE: pick drive d.
  - If loaded[d] & dirty[d]: enter FLUSH with ltrack = cur_track[d]; dirty[d] <= 0.
  - Otherwise: enter LOAD with ltrack = track[d] and cur_track[d] <= track[d].
- FLUSH: SPT sector writes of ltrack. Then re-read track[d]; if it changed, cur_track[d] <= new value. Enter LOAD.
- LOAD: SPT sector reads. Then loaded[d] <= 1, return to IDLE.
- If track[d] changes during LOAD, the drive is re-serviced afterwards. A flush is not needed again unless dirty was set during LOAD; writes during LOAD are expected only from mount races and are allowed.

Per-sector handshake (index s = 0..SPT-1):
- sd_lba = ltrack*SPT + s, computed in 32-bit unsigned arithmetic (zero-extend, then multiply).
- buf_sec = s.
- Assert sd_rd[d] (LOAD) or sd_wr[d] (FLUSH).
- On the rising edge of sd_ack[d]: drop the request.
- On the falling edge of sd_ack[d]: if s == SPT-1, the phase is done; otherwise s <= s+1 and the request is reasserted the next cycle.
- Only the active drive's sd_ack is watched; acks from other drives are ignored.

Eject (img_size_nz = 0): no transfer is started and the buffer is left as is.

## Timing
Reset values:
- All outputs 0.
- sd_lba = 0, buf_drive = 0, buf_sec = 0.
- All per-drive state cleared; FSM in IDLE.

Cycle-level behaviour:
- Service detection to request high: 1 cycle. cpu_wait rises in the same cycle as the first request.
- cpu_wait stays high through every sector and through the FLUSH-to-LOAD change, with no gap.
- cpu_wait falls the cycle after the last falling edge of sd_ack.
- Between sectors, the request reasserts 1 cycle after the falling edge of ack.
- A rising and a falling edge of ack are never seen in the same cycle; ack must be low at least 1 cycle between blocks.
- Reset mid-transfer: outputs return to 0 immediately; loaded and dirty are cleared, so the next transfer is a fresh LOAD.
- A mount pulse and service detection in the same cycle: the mount takes effect first.

## Test plan
- Mount drive 0 (size nonzero), track = 5 → 13 reads with sd_lba 65..77 and buf_sec 0..12; cpu_wait high from the first request until 1 cycle after the 13th ack falls; loaded = 1.
- Loaded track 5, one wr_strobe, then track = 6 → 13 writes with sd_lba 65..77, then 13 reads with sd_lba 78..90; no cpu_wait gap; dirty = 0 at the end.
- Same as above but with the image mounted read-only → no writes; reads only, sd_lba 78..90.
- Drives 0 and 1 both need service in the same cycle → drive 0 is fully served first (buf_drive = 0), then drive 1; busy[1] stays high throughout.
- Remount drive 0 mid-LOAD → the current load finishes, then drive 0 reloads; any dirty state is discarded and no writes are issued.
- Assert reset_n = 0 at sector 7 of a FLUSH → sd_wr = 0 and cpu_wait = 0 asynchronously; after release, only reads are issued.

Source files
------------

// File: rtl/disk_track_loader_if.sv
// Block handshake between the track loader (master) and the HPS virtual-disk port (slave).
interface disk_track_loader_if #(
    parameter int DRIVES = 2,
    parameter int SEC_W  = 4
);
    localparam int DW = (DRIVES > 1) ? $clog2(DRIVES) : 1;

    logic [31:0]       sd_lba;
    logic [DRIVES-1:0] sd_rd;
    logic [DRIVES-1:0] sd_wr;
    logic [DRIVES-1:0] sd_ack;
    logic [DW-1:0]     buf_drive;
    logic [SEC_W-1:0]  buf_sec;

    modport master (
        output sd_lba, sd_rd, sd_wr, buf_drive, buf_sec,
        input  sd_ack
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, buf_drive, buf_sec,
        output sd_ack
    );
endinterface

// File: rtl/disk_track_loader.sv
// Multi-drive track cache: loads whole tracks into per-drive buffers and
// writes dirty tracks back to the image before they are replaced.
module disk_track_loader #(
    parameter int  DRIVES  = 2,
    parameter int  SPT     = 13,
    parameter int  TRACK_W = 6,
    parameter int  SEC_W   = 4,
    localparam int DW      = (DRIVES > 1) ? $clog2(DRIVES) : 1
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic [DRIVES*TRACK_W-1:0] track,
    input  logic [DRIVES-1:0]         img_mounted,
    input  logic                      img_size_nz,
    input  logic                      img_readonly,
    input  logic                      wr_strobe,
    input  logic [DW-1:0]             wr_drive,
    disk_track_loader_if.master       sd,
    output logic                      cpu_wait,
    output logic [DRIVES-1:0]         busy
);
    typedef enum logic [1:0] {IDLE, FLUSH, LOAD} state_t;

    localparam logic [31:0] SPT_L = 32'(SPT);

    state_t             state;
    logic [DRIVES-1:0]  present;
    logic [DRIVES-1:0]  ro;
    logic [DRIVES-1:0]  loaded;
    logic [DRIVES-1:0]  dirty;
    logic [TRACK_W-1:0] cur_track [DRIVES];
    logic [TRACK_W-1:0] req_track [DRIVES];
    logic [DW-1:0]      act;
    logic [TRACK_W-1:0] ltrack;
    logic [SEC_W-1:0]   sec;
    logic [SEC_W-1:0]   sec_nxt;
    logic               ack_q;
    logic               remount;
    logic [DRIVES-1:0]  need;
    logic [DRIVES-1:0]  need_eff;
    logic [DW-1:0]      pick;
    logic               pick_valid;
    logic               ack;
    logic               ack_rise;
    logic               ack_fall;
    logic               last_sec;

    function automatic logic [31:0] lba_of(input logic [TRACK_W-1:0] t, input logic [SEC_W-1:0] s);
        return 32'(t) * SPT_L + 32'(s);
    endfunction

    // A mount pulse in the same cycle overrides present/loaded for the service decision.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        busy       = '0;
        for (int d = 0; d < DRIVES; d++) begin
            req_track[d] = track[d*TRACK_W +: TRACK_W];
            need[d]      = present[d] & (~loaded[d] | (cur_track[d] != req_track[d]));
            need_eff[d]  = img_mounted[d] ? img_size_nz : need[d];
            busy[d]      = need[d] | ((state != IDLE) && (act == DW'(d)));
        end
        for (int d = DRIVES - 1; d >= 0; d--) begin
            if (need_eff[d]) begin
                pick       = DW'(d);
                pick_valid = 1'b1;
            end
        end
    end

    assign ack      = sd.sd_ack[act];
    assign ack_rise = ack & ~ack_q;
    assign ack_fall = ~ack & ack_q;
    assign last_sec = (sec == SEC_W'(SPT - 1));
    assign sec_nxt  = sec + 1'b1;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            present <= '0;
            ro      <= '0;
            loaded  <= '0;
            dirty   <= '0;
            for (int d = 0; d < DRIVES; d++) cur_track[d] <= '0;
            act          <= '0;
            ltrack       <= '0;
            sec          <= '0;
            ack_q        <= 1'b0;
            remount      <= 1'b0;
            sd.sd_lba    <= '0;
            sd.sd_rd     <= '0;
            sd.sd_wr     <= '0;
            sd.buf_drive <= '0;
            sd.buf_sec   <= '0;
            cpu_wait     <= 1'b0;
        end else begin
            ack_q <= (state == IDLE) ? 1'b0 : ack;

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        act          <= pick;
                        sec          <= '0;
                        remount      <= 1'b0;
                        cpu_wait     <= 1'b1;
                        sd.buf_drive <= pick;
                        sd.buf_sec   <= '0;
                        if (loaded[pick] && dirty[pick] && !img_mounted[pick]) begin
                            state        <= FLUSH;
                            ltrack       <= cur_track[pick];
                            dirty[pick]  <= 1'b0;
                            sd.sd_lba    <= lba_of(cur_track[pick], '0);
                            sd.sd_wr[pick] <= 1'b1;
                        end else begin
                            state           <= LOAD;
                            ltrack          <= req_track[pick];
                            cur_track[pick] <= req_track[pick];
                            sd.sd_lba       <= lba_of(req_track[pick], '0);
                            sd.sd_rd[pick]  <= 1'b1;
                        end
                    end
                end

                FLUSH, LOAD: begin
                    if (ack_rise) begin
                        sd.sd_rd <= '0;
                        sd.sd_wr <= '0;
                    end else if (ack_fall) begin
                        if (!last_sec) begin
                            sec        <= sec_nxt;
                            sd.buf_sec <= sec_nxt;
                            sd.sd_lba  <= lba_of(ltrack, sec_nxt);
                            if (state == FLUSH) sd.sd_wr[act] <= 1'b1;
                            else                sd.sd_rd[act] <= 1'b1;
                        end else if (state == FLUSH) begin
                            state          <= LOAD;
                            sec            <= '0;
                            sd.buf_sec     <= '0;
                            ltrack         <= req_track[act];
                            cur_track[act] <= req_track[act];
                            sd.sd_lba      <= lba_of(req_track[act], '0);
                            sd.sd_rd[act]  <= 1'b1;
                        end else begin
                            state       <= IDLE;
                            cpu_wait    <= 1'b0;
                            loaded[act] <= ~(remount | img_mounted[act]);
                        end
                    end
                    // A remount of the active drive forces a reload once this load ends.
                    if (img_mounted[act]) remount <= 1'b1;
                end

                default: state <= IDLE;
            endcase

            if (wr_strobe && present[wr_drive] && loaded[wr_drive] && !ro[wr_drive])
                dirty[wr_drive] <= 1'b1;

            for (int d = 0; d < DRIVES; d++) begin
                if (img_mounted[d]) begin
                    present[d] <= img_size_nz;
                    ro[d]      <= img_readonly;
                    loaded[d]  <= 1'b0;
                    dirty[d]   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_disk_track_loader.sv
// Scoreboard bench: expected block transfers are queued by the stimulus and
// checked by a responder that also plays the HPS ack side.
module tb_disk_track_loader;
    localparam int DRIVES  = 2;
    localparam int SPT     = 13;
    localparam int TRACK_W = 6;
    localparam int SEC_W   = 4;

    typedef struct packed {
        logic             wr;
        logic             drv;
        logic [31:0]      lba;
        logic [SEC_W-1:0] sec;
        logic             last;
    } txn_t;

    logic                      clk_sys = 1'b0;
    logic                      reset_n;
    logic [DRIVES*TRACK_W-1:0] track;
    logic [DRIVES-1:0]         img_mounted;
    logic                      img_size_nz;
    logic                      img_readonly;
    logic                      wr_strobe;
    logic [0:0]                wr_drive;
    logic                      cpu_wait;
    logic [DRIVES-1:0]         busy;

    txn_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   phase    = 0;
    int   hold     = 0;
    int   gap_err  = 0;
    logic pending_last = 1'b0;

    disk_track_loader_if #(.DRIVES(DRIVES), .SEC_W(SEC_W)) sd_bus ();

    disk_track_loader #(
        .DRIVES(DRIVES), .SPT(SPT), .TRACK_W(TRACK_W), .SEC_W(SEC_W)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .track(track),
        .img_mounted(img_mounted),
        .img_size_nz(img_size_nz),
        .img_readonly(img_readonly),
        .wr_strobe(wr_strobe),
        .wr_drive(wr_drive),
        .sd(sd_bus.master),
        .cpu_wait(cpu_wait),
        .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [11:0] trk(input logic [5:0] t1, input logic [5:0] t0);
        return {t1, t0};
    endfunction

    task automatic push_burst(input logic wr, input logic drv, input int base, input int n, input logic last_at_end);
        txn_t t;
        for (int s = 0; s < n; s++) begin
            t.wr   = wr;
            t.drv  = drv;
            t.lba  = 32'(base + s);
            t.sec  = SEC_W'(s);
            t.last = last_at_end && (s == n - 1);
            exp_q.push_back(t);
        end
    endtask

    task automatic apply_stimulus(input logic [11:0] trk_v, input logic [1:0] mnt, input logic nz,
                                  input logic rdo, input logic strb, input logic drv);
        @(negedge clk_sys);
        track        = trk_v;
        img_mounted  = mnt;
        img_size_nz  = nz;
        img_readonly = rdo;
        wr_strobe    = strb;
        wr_drive     = drv;
        @(negedge clk_sys);
        img_mounted  = '0;
        wr_strobe    = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || phase != 0 || cpu_wait) && n < 2000) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        check_output({name, "_timeout"}, 64'(n >= 2000), 64'd0);
        repeat (6) @(negedge clk_sys);
        check_output({name, "_cpu_wait_gap"}, 64'(gap_err), 64'd0);
    endtask

    // HPS side: accept each request, ack for two cycles, then hold ack low for one.
    always @(negedge clk_sys) begin
        logic [DRIVES-1:0] req;
        logic              onehot;
        txn_t              e;
        txn_t              o;
        req    = sd_bus.sd_rd | sd_bus.sd_wr;
        onehot = $onehot(req) && !((|sd_bus.sd_rd) && (|sd_bus.sd_wr));
        if (!reset_n) begin
            sd_bus.sd_ack = '0;
            phase = 0;
            hold  = 0;
        end else begin
            if ((phase == 1 || req != '0) && !cpu_wait) gap_err++;
            case (phase)
                0: begin
                    if (req != '0) begin
                        o.wr   = |sd_bus.sd_wr;
                        o.drv  = req[1];
                        o.lba  = sd_bus.sd_lba;
                        o.sec  = sd_bus.buf_sec;
                        o.last = 1'b0;
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("[TB] FAIL unexpected_req: got wr=%0b drv=%0b lba=%0d sec=%0d, expected no request",
                                     o.wr, o.drv, o.lba, o.sec);
                            pending_last = 1'b1;
                        end else begin
                            e = exp_q.pop_front();
                            check_output("txn", {24'd0, o.wr, o.drv, sd_bus.buf_drive, onehot, o.lba, o.sec},
                                         {24'd0, e.wr, e.drv, e.drv, 1'b1, e.lba, e.sec});
                            pending_last = e.last;
                        end
                        sd_bus.sd_ack[o.drv] = 1'b1;
                        hold  = 0;
                        phase = 1;
                    end
                end
                1: begin
                    hold++;
                    if (hold == 2) begin
                        check_output("req_drop", 64'(req), 64'd0);
                        sd_bus.sd_ack = '0;
                        phase = 2;
                    end
                end
                default: begin
                    check_output("cpu_wait_after_ack", 64'(cpu_wait), 64'(!pending_last));
                    phase = 0;
                end
            endcase
        end
    end

    initial begin
        int   n;
        logic found;
        reset_n      = 1'b1;
        track        = '0;
        img_mounted  = '0;
        img_size_nz  = 1'b0;
        img_readonly = 1'b0;
        wr_strobe    = 1'b0;
        wr_drive     = '0;
        #1 reset_n = 1'b0;
        #2;
        check_output("rst_sd_lba", 64'(sd_bus.sd_lba), 64'd0);
        check_output("rst_sd_rd", 64'(sd_bus.sd_rd), 64'd0);
        check_output("rst_sd_wr", 64'(sd_bus.sd_wr), 64'd0);
        check_output("rst_buf", 64'({sd_bus.buf_drive, sd_bus.buf_sec}), 64'd0);
        check_output("rst_cpu_wait", 64'(cpu_wait), 64'd0);
        check_output("rst_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        #1;
        check_output("idle_busy", 64'(busy), 64'd0);

        // Mount drive 0 at track 5: reads of blocks 65..77
        push_burst(1'b0, 1'b0, 65, 13, 1'b1);
        apply_stimulus(trk(6'd0, 6'd5), 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done("load_t5");
        check_output("load_t5_busy", 64'(busy), 64'd0);

        // Dirty track 5, step to 6: write back 65..77 then read 78..90
        apply_stimulus(trk(6'd0, 6'd5), 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        push_burst(1'b1, 1'b0, 65, 13, 1'b0);
        push_burst(1'b0, 1'b0, 78, 13, 1'b1);
        apply_stimulus(trk(6'd0, 6'd6), 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done("flush_t5");

        // Clean after the flush: track 7 reads 91..103 only
        push_burst(1'b0, 1'b0, 91, 13, 1'b1);
        apply_stimulus(trk(6'd0, 6'd7), 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done("clean_t7");

        // Read-only remount reloads track 7; a strobe must not cause a write-back
        push_burst(1'b0, 1'b0, 91, 13, 1'b1);
        apply_stimulus(trk(6'd0, 6'd7), 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_done("ro_mount");
        apply_stimulus(trk(6'd0, 6'd7), 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        push_burst(1'b0, 1'b0, 78, 13, 1'b1);
        apply_stimulus(trk(6'd0, 6'd6), 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_done("ro_t6");

        // Both drives mounted together: drive 0 track 2 (26..38), then drive 1 track 3 (39..51)
        push_burst(1'b0, 1'b0, 26, 13, 1'b1);
        push_burst(1'b0, 1'b1, 39, 13, 1'b1);
        apply_stimulus(trk(6'd3, 6'd2), 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        n = 0;
        found = 1'b0;
        while (!found && n < 500) begin
            @(negedge clk_sys);
            #1;
            if (sd_bus.sd_rd[1]) found = 1'b1;
            else if (!busy[1]) gap_err++;
            n++;
        end
        check_output("drive1_started", 64'(found), 64'd1);
        check_output("busy1_held", 64'(gap_err), 64'd0);
        wait_done("two_drives");

        // Remount drive 0 mid-load of track 4: load finishes, then reloads, no write-back
        push_burst(1'b0, 1'b0, 52, 13, 1'b1);
        push_burst(1'b0, 1'b0, 52, 13, 1'b1);
        apply_stimulus(trk(6'd3, 6'd4), 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (exp_q.size() > 22 && n < 500) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        check_output("mid_load_reached", 64'(n >= 500), 64'd0);
        apply_stimulus(trk(6'd3, 6'd4), 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        apply_stimulus(trk(6'd3, 6'd4), 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done("remount");

        // Reset during sector 7 of a write-back of track 4
        apply_stimulus(trk(6'd3, 6'd4), 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        push_burst(1'b1, 1'b0, 52, 8, 1'b0);
        apply_stimulus(trk(6'd3, 6'd8), 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        n = 0;
        found = 1'b0;
        while (!found && n < 500) begin
            @(negedge clk_sys);
            #1;
            if (exp_q.size() == 0 && sd_bus.sd_wr[0]) found = 1'b1;
            n++;
        end
        check_output("flush_sec7_seen", 64'(found), 64'd1);
        reset_n = 1'b0;
        #1;
        check_output("async_rst_sd_wr", 64'(sd_bus.sd_wr), 64'd0);
        check_output("async_rst_cpu_wait", 64'(cpu_wait), 64'd0);
        check_output("async_rst_lba", 64'(sd_bus.sd_lba), 64'd0);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_sys);
        #1;
        check_output("post_rst_busy", 64'(busy), 64'd0);
        push_burst(1'b0, 1'b0, 104, 13, 1'b1);
        apply_stimulus(trk(6'd3, 6'd8), 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done("post_rst_load");

        check_output("final_busy", 64'(busy), 64'd0);
        check_output("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
